// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register pipe: opcode encoding, divider
// FSM states and a helper that classifies the multi-cycle operations.
package instr_register_pkg;

  localparam int OPCODE_W = 4;

  typedef enum logic [OPCODE_W-1:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_t;

  function automatic logic is_div_op(input opcode_t op);
    return (op == DIV) || (op == MOD);
  endfunction

endpackage

// File: rtl/instr_register_pipe_divider.sv
// Iterative signed divider: radix-2 restoring division on magnitudes, one
// quotient bit per cycle, signs applied combinationally once DONE is reached.
module seq_divider
  import instr_register_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic                done,
  output logic signed [W-1:0] quotient,
  output logic signed [W-1:0] remainder,
  output logic                dz
);

  localparam int CNT_W = $clog2(W);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     quo;
  logic [W-1:0]     rem;
  logic [W-1:0]     dvs;
  logic             neg_q;
  logic             neg_r;
  logic [W-1:0]     a_mag;
  logic [W-1:0]     b_mag;
  logic [W:0]       trial;
  logic [W:0]       diff;

  // |MIN| still fits as an unsigned W-bit magnitude, so MIN/-1 needs no special case.
  assign a_mag = a[W-1] ? (~a + 1'b1) : a;
  assign b_mag = b[W-1] ? (~b + 1'b1) : b;
  assign dz    = (b == '0);
  assign trial = {rem, quo[W-1]};
  assign diff  = trial - {1'b0, dvs};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= DIV_IDLE;
      cnt   <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start && !dz) begin
            quo   <= a_mag;
            rem   <= '0;
            dvs   <= b_mag;
            neg_q <= a[W-1] ^ b[W-1];
            neg_r <= a[W-1];
            cnt   <= '0;
            state <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          rem <= diff[W] ? trial[W-1:0] : diff[W-1:0];
          quo <= {quo[W-2:0], ~diff[W]};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(W - 1)) state <= DIV_DONE;
        end
        DIV_DONE: state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

  assign done      = (state == DIV_DONE);
  assign quotient  = neg_q ? -$signed(quo) : $signed(quo);
  assign remainder = neg_r ? -$signed(rem) : $signed(rem);

endmodule

// File: rtl/instr_register_pipe.sv
// Instruction register file with a built-in signed ALU: stores {opcode, a, b, result}
// per entry; DIV/MOD run on a sequential divider and hold off the writer meanwhile.
module instr_register_pipe
  import instr_register_pkg::*;
#(
  parameter  int OP_WIDTH = 32,
  parameter  int DEPTH    = 32,
  parameter  int ADDR_W   = $clog2(DEPTH),
  localparam int INSTR_W  = OPCODE_W + 4 * OP_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  opcode_t                    opcode,
  input  logic signed [OP_WIDTH-1:0] operand_a,
  input  logic signed [OP_WIDTH-1:0] operand_b,
  input  logic [ADDR_W-1:0]          write_pointer,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          read_pointer,
  output logic                       rd_valid,
  output logic [INSTR_W-1:0]         instruction_word,
  output logic                       div_by_zero
);

  localparam int RES_W = 2 * OP_WIDTH;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef struct packed {
    opcode_t                    opcode;
    logic signed [OP_WIDTH-1:0] op_a;
    logic signed [OP_WIDTH-1:0] op_b;
    logic signed [RES_W-1:0]    result;
  } instruction_t;

  instruction_t mem [DEPTH];

  logic                       accept;
  logic                       div_start;
  logic                       div_done;
  logic                       div_dz;
  logic signed [OP_WIDTH-1:0] div_q;
  logic signed [OP_WIDTH-1:0] div_r;
  logic [ADDR_W-1:0]          div_ptr;
  opcode_t                    div_op;
  logic signed [OP_WIDTH-1:0] div_a;
  logic signed [OP_WIDTH-1:0] div_b;
  logic signed [RES_W-1:0]    a_ext;
  logic signed [RES_W-1:0]    b_ext;
  logic signed [RES_W-1:0]    alu_result;
  logic signed [RES_W-1:0]    div_result;
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  instruction_t               wr_data;

  assign accept    = wr_valid && wr_ready;
  assign div_start = accept && is_div_op(opcode) && !div_dz;
  assign a_ext     = {{OP_WIDTH{operand_a[OP_WIDTH-1]}}, operand_a};
  assign b_ext     = {{OP_WIDTH{operand_b[OP_WIDTH-1]}}, operand_b};

  // DIV/MOD fall to zero here; that value is only stored for the divide-by-zero case.
  always_comb begin
    alu_result = '0;
    case (opcode)
      PASSA:   alu_result = a_ext;
      PASSB:   alu_result = b_ext;
      ADD:     alu_result = a_ext + b_ext;
      SUB:     alu_result = a_ext - b_ext;
      MULT:    alu_result = a_ext * b_ext;
      default: alu_result = '0;
    endcase
  end

  seq_divider #(.W(OP_WIDTH)) u_divider (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (div_start),
    .a         (operand_a),
    .b         (operand_b),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r),
    .dz        (div_dz)
  );

  assign div_result = (div_op == DIV) ? RES_W'(div_q) : RES_W'(div_r);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = write_pointer;
    wr_data = '{opcode, operand_a, operand_b, alu_result};
    if (div_done) begin
      wr_en   = 1'b1;
      wr_addr = div_ptr;
      wr_data = '{div_op, div_a, div_b, div_result};
    end else if (accept && !div_start) begin
      wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ready    <= 1'b1;
      div_by_zero <= 1'b0;
      div_ptr     <= '0;
      div_op      <= ZERO;
      div_a       <= '0;
      div_b       <= '0;
    end else begin
      div_by_zero <= accept && is_div_op(opcode) && div_dz;
      if (div_start) begin
        wr_ready <= 1'b0;
        div_ptr  <= write_pointer;
        div_op   <= opcode;
        div_a    <= operand_a;
        div_b    <= operand_b;
      end else if (div_done) begin
        wr_ready <= 1'b1;
      end
    end
  end

  // NOTE: the store is reset entry by entry because every entry must read back as ZERO after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en && ({1'b0, wr_addr} < DEPTH_EXT)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Reading the pre-edge array gives read-before-write on a shared entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid         <= 1'b0;
      instruction_word <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        instruction_word <= ({1'b0, read_pointer} < DEPTH_EXT) ? mem[read_pointer] : '0;
      end
    end
  end

endmodule

// File: tb/tb_instr_register_pipe.sv
// Self-checking bench: a behavioural register-file model is compared with the DUT
// every cycle, and directed vectors pin a few results to hand-computed literals.
module tb_instr_register_pipe;
  import instr_register_pkg::*;

  localparam int OP_WIDTH = 32;
  localparam int DEPTH    = 32;
  localparam int ADDR_W   = 5;
  localparam int RES_W    = 64;
  localparam int INSTR_W  = 4 + 4 * OP_WIDTH;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                wr_valid = 1'b0;
  logic                wr_ready;
  opcode_t             opcode = ZERO;
  logic [31:0]         operand_a = '0;
  logic [31:0]         operand_b = '0;
  logic [ADDR_W-1:0]   write_pointer = '0;
  logic                rd_en = 1'b0;
  logic [ADDR_W-1:0]   read_pointer = '0;
  logic                rd_valid;
  logic [INSTR_W-1:0]  instruction_word;
  logic                div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_register_pipe #(.OP_WIDTH(OP_WIDTH), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .opcode           (opcode),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .write_pointer    (write_pointer),
    .rd_en            (rd_en),
    .read_pointer     (read_pointer),
    .rd_valid         (rd_valid),
    .instruction_word (instruction_word),
    .div_by_zero      (div_by_zero)
  );

  task automatic check(input string name, input logic [INSTR_W-1:0] got, input logic [INSTR_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [63:0] sext(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] model_result(input opcode_t op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ea = $signed(sext(a));
    logic signed [63:0] eb = $signed(sext(b));
    logic signed [31:0] sa = $signed(a);
    logic signed [31:0] sb = $signed(b);
    case (op)
      PASSA: return ea;
      PASSB: return eb;
      ADD:   return ea + eb;
      SUB:   return ea - eb;
      MULT:  return ea * eb;
      DIV: begin
        if (b == 0) return 64'd0;
        if (a == MIN && b == 32'hFFFF_FFFF) return sext(MIN);
        return sext(sa / sb);
      end
      MOD: begin
        if (b == 0) return 64'd0;
        if (a == MIN && b == 32'hFFFF_FFFF) return 64'd0;
        return sext(sa % sb);
      end
      default: return 64'd0;
    endcase
  endfunction

  logic [INSTR_W-1:0] m_mem [DEPTH];
  logic [INSTR_W-1:0] m_word;
  logic [INSTR_W-1:0] m_pend;
  logic [ADDR_W-1:0]  m_ptr;
  logic               m_rv;
  logic               m_dz;
  logic               m_ready;
  int                 m_left;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
      m_word  <= '0;
      m_pend  <= '0;
      m_ptr   <= '0;
      m_rv    <= 1'b0;
      m_dz    <= 1'b0;
      m_ready <= 1'b1;
      m_left  <= 0;
    end else begin
      m_rv <= rd_en;
      if (rd_en) m_word <= m_mem[read_pointer];
      m_dz <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_mem[m_ptr] <= m_pend;
          m_ready      <= 1'b1;
        end
      end else if (wr_valid && m_ready) begin
        if (is_div_op(opcode) && operand_b != 0) begin
          m_pend  <= {opcode, operand_a, operand_b, model_result(opcode, operand_a, operand_b)};
          m_ptr   <= write_pointer;
          m_left  <= OP_WIDTH + 1;
          m_ready <= 1'b0;
        end else begin
          m_mem[write_pointer] <= {opcode, operand_a, operand_b, model_result(opcode, operand_a, operand_b)};
          m_dz <= is_div_op(opcode);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("rd_valid", INSTR_W'(rd_valid), INSTR_W'(m_rv));
      check("wr_ready", INSTR_W'(wr_ready), INSTR_W'(m_ready));
      check("div_by_zero", INSTR_W'(div_by_zero), INSTR_W'(m_dz));
      check("instruction_word", instruction_word, m_word);
    end
  end

  // ---------------- directed stimulus ----------------
  logic [INSTR_W-1:0] word;

  task automatic do_write(input opcode_t op, input logic [31:0] a, input logic [31:0] b, input logic [ADDR_W-1:0] p);
    int n = 0;
    wr_valid = 1'b1; opcode = op; operand_a = a; operand_b = b; write_pointer = p;
    while (!wr_ready && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 200) check("write_accept_timeout", 1, 0);
    @(posedge clk); #2;
    wr_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!wr_ready && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 200) check("wr_ready_timeout", 1, 0);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] p, output logic [INSTR_W-1:0] w);
    rd_en = 1'b1; read_pointer = p;
    @(posedge clk); #2;
    rd_en = 1'b0;
    w = instruction_word;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    check("reset_wr_ready", INSTR_W'(wr_ready), 1);
    check("reset_word", instruction_word, '0);

    // Back-to-back reads of every entry after reset.
    for (int i = 0; i < DEPTH; i++) begin
      rd_en = 1'b1; read_pointer = ADDR_W'(i);
      @(posedge clk); #2;
    end
    rd_en = 1'b0;
    check("reset_entry31", instruction_word, '0);

    do_write(ADD, 32'hFFFF_FFFB, 32'd3, 5'd4);
    do_read(5'd4, word);
    check("add_result", INSTR_W'(word[63:0]), INSTR_W'(64'hFFFF_FFFF_FFFF_FFFE));
    check("add_opcode", INSTR_W'(word[INSTR_W-1 -: 4]), INSTR_W'(ADD));
    do_write(SUB, 32'd3, 32'd5, 5'd5);
    do_read(5'd5, word);
    check("sub_result", INSTR_W'(word[63:0]), INSTR_W'(64'hFFFF_FFFF_FFFF_FFFE));
    do_write(MULT, 32'h7FFF_FFFF, 32'd2, 5'd31);
    do_read(5'd31, word);
    check("mult_big", INSTR_W'(word[63:0]), INSTR_W'(64'h0000_0000_FFFF_FFFE));
    do_write(MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 5'd6);
    do_read(5'd6, word);
    check("mult_neg", INSTR_W'(word[63:0]), INSTR_W'(64'd12));
    do_write(PASSA, 32'h8000_0001, 32'd9, 5'd12);
    do_write(PASSB, 32'd1, 32'hFFFF_0000, 5'd13);
    do_write(ZERO, 32'd7, 32'd7, 5'd14);

    do_write(DIV, 32'hFFFF_FFF9, 32'd2, 5'd0);
    check("div_wr_ready_low", INSTR_W'(wr_ready), 0);
    wait_ready();
    do_read(5'd0, word);
    check("div_result", INSTR_W'(word[63:0]), INSTR_W'(64'hFFFF_FFFF_FFFF_FFFD));
    do_write(MOD, 32'hFFFF_FFF9, 32'd2, 5'd1);
    do_write(ADD, 32'd1, 32'd1, 5'd3);   // held through BUSY until wr_ready returns
    do_read(5'd1, word);
    check("mod_result", INSTR_W'(word[63:0]), INSTR_W'(64'hFFFF_FFFF_FFFF_FFFF));
    do_read(5'd3, word);
    check("held_write", INSTR_W'(word[63:0]), INSTR_W'(64'd2));
    do_write(DIV, 32'd100, 32'hFFFF_FFF9, 5'd2);
    wait_ready();

    do_write(ADD, 32'd5, 32'd5, 5'd8);
    do_write(DIV, 32'd9, 32'd0, 5'd8);
    check("dz_pulse", INSTR_W'(div_by_zero), 1);
    check("dz_wr_ready", INSTR_W'(wr_ready), 1);
    do_read(5'd8, word);
    check("dz_result", INSTR_W'(word[63:0]), INSTR_W'(64'd0));
    check("dz_pulse_gone", INSTR_W'(div_by_zero), 0);

    do_write(DIV, MIN, 32'hFFFF_FFFF, 5'd9);
    wait_ready();
    do_write(MOD, MIN, 32'hFFFF_FFFF, 5'd10);
    wait_ready();
    do_read(5'd9, word);
    check("div_overflow", INSTR_W'(word[63:0]), INSTR_W'(64'hFFFF_FFFF_8000_0000));
    do_read(5'd10, word);
    check("mod_overflow", INSTR_W'(word[63:0]), INSTR_W'(64'd0));

    // Same-edge write and read of entry 7.
    do_write(ADD, 32'd1, 32'd2, 5'd7);
    wr_valid = 1'b1; opcode = SUB; operand_a = 32'd10; operand_b = 32'd4; write_pointer = 5'd7;
    rd_en = 1'b1; read_pointer = 5'd7;
    @(posedge clk); #2;
    wr_valid = 1'b0; rd_en = 1'b0;
    check("rbw_old", INSTR_W'(instruction_word[63:0]), INSTR_W'(64'd3));
    do_read(5'd7, word);
    check("rbw_new", INSTR_W'(word[63:0]), INSTR_W'(64'd6));

    // Reset in the middle of a divide.
    do_write(DIV, 32'd50, 32'd5, 5'd11);
    repeat (10) begin @(posedge clk); #2; end
    reset_n = 1'b0;
    repeat (2) begin @(posedge clk); #2; end
    reset_n = 1'b1;
    check("abort_wr_ready", INSTR_W'(wr_ready), 1);
    repeat (40) begin @(posedge clk); #2; end
    do_read(5'd11, word);
    check("abort_entry", word, '0);
    do_read(5'd7, word);
    check("abort_cleared", word, '0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
